mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store initiator between the datapath's memory stage and the word-organised `data_memory`. Takes one byte-addressed load or store request at a time, drives the memory's `memread`/`memwrite`/`address`/`write_data` inputs and samples `read_data`. Performs byte/halfword extraction with sign or zero extension. Implements SB/SH as a read-modify-write, because the memory only writes whole words.

## Interface
- ADDR_W, 13: memory word-address width (8192 words).
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  a request is presented.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_op  in  3  000 byte, 001 half, 011 word, 100 byte unsigned, 101 half unsigned; all other codes illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or half is used for SB/SH.
- resp_valid  out  1  response available; held until resp_ready.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- resp_err  out  1  request rejected; no memory access was made.
- mem_address  out  ADDR_W  to `data_memory` address.
- mem_write_data  out  32  to `data_memory` write_data.
- mem_memread  out  1  to `data_memory` memread.
- mem_memwrite  out  1  to `data_memory` memwrite.
- mem_read_data  in  32  from `data_memory` read_data.

## Operation
- States: IDLE, RD, WR, RESP. All outputs are registered.
- Acceptance: `req_valid & req_ready` at a rising edge. Latch store, op, addr[1:0] and wdata. Load `mem_address <= req_addr[ADDR_W+1:2]`.
- Error check at acceptance. Any of these conditions goes straight to RESP with resp_err=1 and no memory strobes:
  - illegal op;
  - unsigned op with req_store=1;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0;
  - req_addr[31:ADDR_W+2] ≠ 0.
- Transitions:
  - Load: IDLE→RD→RESP.
  - SW: IDLE→WR→RESP.
  - SB/SH: IDLE→RD→WR→RESP.
  - RESP→IDLE when resp_ready=1.
- RD: mem_memread=1 for exactly one cycle. The word on mem_read_data is sampled at the edge that leaves RD.
- WR: mem_memwrite=1 for exactly one cycle. mem_write_data holds the full word for SW, or the merged word for SB/SH. The memory commits at the edge that leaves WR.
- Byte lanes are big-endian:
  - offset 0 = bits [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0];
  - half at offset 0 = [31:16], half at offset 2 = [15:0].
- Loads: the selected lane is right-justified. op 000/001 sign-extend from bit 7/15; op 100/101 zero-extend.
- SB/SH merge: the sampled word with the addressed lane replaced by req_wdata[7:0] or [15:0]. All other lanes are unchanged.
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - req_ready=0 while rst_n=0, then 1 from the first edge after release.
  - resp_valid, resp_err, mem_memread and mem_memwrite go to 0.
  - resp_rdata, mem_address and mem_write_data go to 0.

## Timing
- Latency from the accept edge to resp_valid high:
  - 2 edges for LW/LB/LH/LBU/LHU and SW;
  - 3 edges for SB/SH;
  - 1 edge for errors.
- Throughput: one request per 2 cycles at best, because req_ready is low from the accept edge until the cycle after the response is taken.
- req_valid is ignored outside IDLE. Request fields are don't-care after acceptance.
- resp_valid and resp_rdata are stable until the edge where resp_ready=1. A response with resp_ready already high lasts one cycle.
- mem_memread and mem_memwrite are never high in the same cycle. Neither is high in IDLE or RESP.
- mem_address is constant from acceptance through RESP.
- Reset mid-operation:
  - If rst_n falls during WR, mem_memwrite drops immediately. No write is committed at an edge where rst_n=0.
  - If rst_n falls during RD, the read data is discarded.
  - No response is produced for an aborted request.

## Test plan
- Reset: rst_n=0 mid-RD of an LW → all outputs 0 immediately. After release, req_ready=1 and resp_valid never rises for the aborted request.
- SW addr 0x10, wdata 0x12345678, then LW addr 0x10 → mem_address=4 with one memwrite pulse. The load gives resp_rdata=0x12345678, resp_err=0 and latency 2.
- Byte/half loads with memory word 4 = 0x80FF7F01:
  - LB 0x10 → 0xFFFFFF80;
  - LBU 0x11 → 0x000000FF;
  - LB 0x12 → 0x0000007F;
  - LH 0x10 → 0xFFFF80FF;
  - LHU 0x12 → 0x00007F01.
- SB 0x11 with wdata 0xAA over word 0x12345678 → one read then one write; memory word 4 = 0x12AA5678 and latency 3. SH 0x12 with 0xBEEF → 0x12AABEEF.
- Errors, each giving resp_err=1 one edge after accept with no memread or memwrite pulses:
  - LW 0x13;
  - LH 0x11;
  - op 111;
  - store op 100;
  - addr 0x00008000.
- Backpressure: hold resp_ready=0 for 5 cycles after an LW → resp_valid and resp_rdata stay stable and req_ready stays 0. resp_ready=1 → IDLE next cycle. A back-to-back request is accepted on the following edge.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte-addressed load/store initiator for a word-organised data memory
//
// Takes one load or store request at a time, and does byte or halfword extraction with sign or
// zero extension. Sub-word stores are done as read-modify-write because the memory only writes
// whole words. Byte lanes are big-endian: offset 0 is bits [31:24].
//
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_req_*/o_req_ready        request handshake (store flag, op code, byte address, store data)
//   o_resp_*/i_resp_ready      response handshake (extended load data, error flag)
//   o_mem_*/i_mem_read_data    data_memory strobes, word address, write data and read data

module mem_access_unit #(
    parameter int ADDR_W = 13
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_store,
    input  logic [2:0]        i_req_op,
    input  logic [31:0]       i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [31:0]       o_resp_rdata,
    output logic              o_resp_err,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [31:0]       o_mem_write_data,
    output logic              o_mem_memread,
    output logic              o_mem_memwrite,
    input  logic [31:0]       i_mem_read_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } state_t;

    state_t              r_state;
    logic                r_req_ready;
    logic                r_store;
    logic [2:0]          r_op;
    logic [1:0]          r_off;
    logic [15:0]         r_wdata;
    logic                r_resp_valid;
    logic [31:0]         r_resp_rdata;
    logic                r_resp_err;
    logic [ADDR_W-1:0]   r_mem_address;
    logic [31:0]         r_mem_write_data;
    logic                r_mem_memread;
    logic                r_mem_memwrite;

    logic                w_accept;
    logic                w_op_legal;
    logic                w_err;
    logic                w_needs_read;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load_val;
    logic [31:0]         w_merge;

    assign o_req_ready      = r_req_ready;
    assign o_resp_valid     = r_resp_valid;
    assign o_resp_rdata     = r_resp_rdata;
    assign o_resp_err       = r_resp_err;
    assign o_mem_address    = r_mem_address;
    assign o_mem_write_data = r_mem_write_data;
    assign o_mem_memread    = r_mem_memread;
    assign o_mem_memwrite   = r_mem_memwrite;

    // r_req_ready is only ever high in IDLE, so it doubles as the state qualifier.
    assign w_accept = i_req_valid & r_req_ready;

    always_comb begin
        w_op_legal = 1'b0;
        case (i_req_op)
            3'b000, 3'b001, 3'b011, 3'b100, 3'b101: w_op_legal = 1'b1;
            default:                                w_op_legal = 1'b0;
        endcase
    end

    assign w_err = ~w_op_legal
                 | (i_req_store & i_req_op[2])
                 | ((i_req_op[1:0] == 2'b01) & i_req_addr[0])
                 | ((i_req_op[1:0] == 2'b11) & (i_req_addr[1:0] != 2'b00))
                 | (|i_req_addr[31:ADDR_W+2]);

    // Every load reads; a store reads first only when it does not cover the whole word.
    assign w_needs_read = ~i_req_store | (i_req_op[1:0] != 2'b11);

    // Lane selection and extension of the word sampled at the end of RD.
    always_comb begin
        w_byte = 8'h00;
        case (r_off)
            2'd0: w_byte = i_mem_read_data[31:24];
            2'd1: w_byte = i_mem_read_data[23:16];
            2'd2: w_byte = i_mem_read_data[15:8];
            2'd3: w_byte = i_mem_read_data[7:0];
            default: w_byte = 8'h00;
        endcase
        w_half = r_off[1] ? i_mem_read_data[15:0] : i_mem_read_data[31:16];

        w_load_val = i_mem_read_data;
        case (r_op[1:0])
            2'b00:   w_load_val = {{24{~r_op[2] & w_byte[7]}}, w_byte};
            2'b01:   w_load_val = {{16{~r_op[2] & w_half[15]}}, w_half};
            default: w_load_val = i_mem_read_data;
        endcase
    end

    // Read-modify-write merge for SB/SH: only the addressed lane is replaced.
    always_comb begin
        w_merge = i_mem_read_data;
        if (r_op[1:0] == 2'b01) begin
            if (r_off[1]) begin
                w_merge[15:0] = r_wdata;
            end else begin
                w_merge[31:16] = r_wdata;
            end
        end else begin
            case (r_off)
                2'd0: w_merge[31:24] = r_wdata[7:0];
                2'd1: w_merge[23:16] = r_wdata[7:0];
                2'd2: w_merge[15:8]  = r_wdata[7:0];
                2'd3: w_merge[7:0]   = r_wdata[7:0];
                default: w_merge = i_mem_read_data;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= S_IDLE;
            r_req_ready      <= 1'b0;
            r_store          <= 1'b0;
            r_op             <= 3'b000;
            r_off            <= 2'b00;
            r_wdata          <= 16'h0000;
            r_resp_valid     <= 1'b0;
            r_resp_rdata     <= 32'h0000_0000;
            r_resp_err       <= 1'b0;
            r_mem_address    <= '0;
            r_mem_write_data <= 32'h0000_0000;
            r_mem_memread    <= 1'b0;
            r_mem_memwrite   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req_ready   <= 1'b0;
                        r_store       <= i_req_store;
                        r_op          <= i_req_op;
                        r_off         <= i_req_addr[1:0];
                        r_wdata       <= i_req_wdata[15:0];
                        r_mem_address <= i_req_addr[ADDR_W+1:2];
                        if (w_err) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'h0000_0000;
                        end else if (w_needs_read) begin
                            r_state       <= S_RD;
                            r_mem_memread <= 1'b1;
                        end else begin
                            r_state          <= S_WR;
                            r_mem_memwrite   <= 1'b1;
                            r_mem_write_data <= i_req_wdata;
                        end
                    end else begin
                        // Also raises ready on the first edge after reset release.
                        r_req_ready <= 1'b1;
                    end
                end
                S_RD: begin
                    r_mem_memread <= 1'b0;
                    if (r_store) begin
                        r_state          <= S_WR;
                        r_mem_memwrite   <= 1'b1;
                        r_mem_write_data <= w_merge;
                    end else begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= w_load_val;
                    end
                end
                S_WR: begin
                    r_mem_memwrite <= 1'b0;
                    r_state        <= S_RESP;
                    r_resp_valid   <= 1'b1;
                    r_resp_err     <= 1'b0;
                    r_resp_rdata   <= 32'h0000_0000;
                end
                S_RESP: begin
                    if (i_resp_ready) begin
                        r_state      <= S_IDLE;
                        r_req_ready  <= 1'b1;
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= 32'h0000_0000;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit against a byte-level memory model
module tb_mem_access_unit;

    localparam int ADDR_W = 13;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              req_valid  = 1'b0;
    logic              req_store  = 1'b0;
    logic [2:0]        req_op     = 3'b000;
    logic [31:0]       req_addr   = 32'h0;
    logic [31:0]       req_wdata  = 32'h0;
    logic              resp_ready = 1'b0;
    logic              req_ready;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic              mem_memread;
    logic              mem_memwrite;
    logic [31:0]       mem_read_data;

    bit [31:0] dmem    [0:8191];
    bit [7:0]  ref_mem [0:32767];

    int          n_chk  = 0;
    int          n_fail = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    bit          chk_en = 1'b0;
    bit          busy   = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_err   = 1'b0;
    logic [12:0] exp_addr  = 13'h0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_store      (req_store),
        .i_req_op         (req_op),
        .i_req_addr       (req_addr),
        .i_req_wdata      (req_wdata),
        .o_resp_valid     (resp_valid),
        .i_resp_ready     (resp_ready),
        .o_resp_rdata     (resp_rdata),
        .o_resp_err       (resp_err),
        .o_mem_address    (mem_address),
        .o_mem_write_data (mem_write_data),
        .o_mem_memread    (mem_memread),
        .o_mem_memwrite   (mem_memwrite),
        .i_mem_read_data  (mem_read_data)
    );

    // data_memory: combinational read while memread, write committed on a clock edge out of reset.
    assign mem_read_data = mem_memread ? dmem[mem_address] : 32'hDEAD_BEEF;
    always @(posedge clk) begin
        if (rst_n && mem_memwrite) dmem[mem_address] <= mem_write_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w], ref_mem[4*w+1], ref_mem[4*w+2], ref_mem[4*w+3]};
    endfunction

    // Reference behaviour from the request rules: sizes, alignment, big-endian byte order.
    task automatic model(input bit st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                         output logic err, output logic [31:0] rd, output int lat,
                         output int nrd, output int nwr);
        int          size;
        bit          legal;
        bit          uns;
        logic [31:0] v;
        legal = 1'b1;
        uns   = 1'b0;
        size  = 1;
        case (op)
            3'b000: size = 1;
            3'b001: size = 2;
            3'b011: size = 4;
            3'b100: begin size = 1; uns = 1'b1; end
            3'b101: begin size = 2; uns = 1'b1; end
            default: legal = 1'b0;
        endcase
        err = !legal || (st && uns) || ((a % 32'(size)) != 0) || (a >= 32'h8000);
        rd  = 32'h0;
        lat = 1;
        nrd = 0;
        nwr = 0;
        if (!err) begin
            if (!st) begin
                v = 32'h0;
                for (int i = 0; i < size; i++) v = (v << 8) | 32'(ref_mem[a + 32'(i)]);
                if (!uns && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
                rd  = v;
                lat = 2;
                nrd = 1;
            end else begin
                for (int i = 0; i < size; i++) ref_mem[a + 32'(i)] = 8'(wd >> (8*(size-1-i)));
                lat = (size == 4) ? 2 : 3;
                nrd = (size == 4) ? 0 : 1;
                nwr = 1;
            end
        end
    endtask

    // Per-cycle compare, sampled on the falling edge.
    task automatic cycle_check();
        if (mem_memread)  rd_cnt++;
        if (mem_memwrite) wr_cnt++;
        if (chk_en) begin
            check("cyc_strobe_excl", 32'(mem_memread & mem_memwrite), 32'h0);
            if (resp_valid) begin
                check("cyc_rdata", resp_rdata, exp_rdata);
                check("cyc_err", 32'(resp_err), 32'(exp_err));
                check("cyc_strobe_resp", 32'(mem_memread | mem_memwrite), 32'h0);
            end
            if (req_ready) check("cyc_strobe_idle", 32'(mem_memread | mem_memwrite), 32'h0);
            if (busy) check("cyc_addr", 32'(mem_address), 32'(exp_addr));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        cycle_check();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 32'({req_ready, resp_valid, resp_err, mem_memread, mem_memwrite}), 32'h0);
        check({tag, "_rdata"}, resp_rdata, 32'h0);
        check({tag, "_addr"}, 32'(mem_address), 32'h0);
        check({tag, "_wdata"}, mem_write_data, 32'h0);
    endtask

    task automatic do_req(input bit st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input int hold, input bit has_lit, input logic [31:0] lit);
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat, e_nrd, e_nwr, lat, t, r0, w0;
        model(st, op, a, wd, e_err, e_rd, e_lat, e_nrd, e_nwr);
        exp_rdata = e_rd;
        exp_err   = e_err;
        exp_addr  = a[14:2];
        t = 0;
        while (!req_ready && t < 20) begin cyc(); t++; end
        check("ready_idle", 32'(req_ready), 32'h1);
        r0 = rd_cnt;
        w0 = wr_cnt;
        req_valid  = 1'b1;
        req_store  = st;
        req_op     = op;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = 1'b0;
        cyc();
        busy = 1'b1;
        check("accepted", 32'(req_ready), 32'h0);
        req_valid = 1'b0;
        req_store = 1'($urandom_range(0, 1));
        req_op    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 8) begin cyc(); lat++; end
        check("latency", 32'(lat), 32'(e_lat));
        check("resp_err", 32'(resp_err), 32'(e_err));
        check("resp_rdata", resp_rdata, e_rd);
        if (has_lit) check("rdata_lit", resp_rdata, lit);
        repeat (hold) begin
            cyc();
            check("bp_valid", 32'(resp_valid), 32'h1);
            check("bp_rdata", resp_rdata, e_rd);
            check("bp_ready", 32'(req_ready), 32'h0);
        end
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        busy = 1'b0;
        check("resp_taken", 32'(resp_valid), 32'h0);
        check("ready_back", 32'(req_ready), 32'h1);
        check("rd_pulses", 32'(rd_cnt - r0), 32'(e_nrd));
        check("wr_pulses", 32'(wr_cnt - w0), 32'(e_nwr));
        if (st) check("mem_word", dmem[a[14:2]], ref_word(int'(a[14:2])));
    endtask

    task automatic abort_req(input bit st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
        bit seen;
        req_valid = 1'b1;
        req_store = st;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check(st ? "abort_memwrite_up" : "abort_memread_up", 32'(st ? mem_memwrite : mem_memread), 32'h1);
        #1 rst_n = 1'b0;
        #1 check_all_zero("abort");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            cyc();
            if (resp_valid) seen = 1'b1;
        end
        check("abort_no_resp", 32'(seen), 32'h0);
        check("abort_ready", 32'(req_ready), 32'h1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1;
        check("ready_before_edge", 32'(req_ready), 32'h0);
        cyc();
        check("ready_after_rst", 32'(req_ready), 32'h1);

        abort_req(1'b0, 3'b011, 32'h10, 32'h0);
        abort_req(1'b1, 3'b011, 32'h20, 32'hCAFE_F00D);
        check("abort_no_commit", dmem[8], 32'h0);

        chk_en = 1'b1;
        do_req(1'b1, 3'b011, 32'h10, 32'h1234_5678, 0, 1'b1, 32'h0);
        check("sw_addr", 32'(mem_address), 32'h4);
        check("sw_word_lit", dmem[4], 32'h1234_5678);
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 0, 1'b1, 32'h1234_5678);

        do_req(1'b1, 3'b011, 32'h10, 32'h80FF_7F01, 0, 1'b0, 32'h0);
        do_req(1'b0, 3'b000, 32'h10, 32'h0, 0, 1'b1, 32'hFFFF_FF80);
        do_req(1'b0, 3'b100, 32'h11, 32'h0, 0, 1'b1, 32'h0000_00FF);
        do_req(1'b0, 3'b000, 32'h12, 32'h0, 0, 1'b1, 32'h0000_007F);
        do_req(1'b0, 3'b001, 32'h10, 32'h0, 0, 1'b1, 32'hFFFF_80FF);
        do_req(1'b0, 3'b101, 32'h12, 32'h0, 0, 1'b1, 32'h0000_7F01);

        do_req(1'b1, 3'b011, 32'h10, 32'h1234_5678, 0, 1'b0, 32'h0);
        do_req(1'b1, 3'b000, 32'h11, 32'hFFFF_FFAA, 0, 1'b0, 32'h0);
        check("sb_word_lit", dmem[4], 32'h12AA_5678);
        do_req(1'b1, 3'b001, 32'h12, 32'h0000_BEEF, 0, 1'b0, 32'h0);
        check("sh_word_lit", dmem[4], 32'h12AA_BEEF);

        do_req(1'b0, 3'b011, 32'h13, 32'h0, 0, 1'b0, 32'h0);
        do_req(1'b0, 3'b001, 32'h11, 32'h0, 0, 1'b0, 32'h0);
        do_req(1'b0, 3'b111, 32'h10, 32'h0, 0, 1'b0, 32'h0);
        do_req(1'b1, 3'b100, 32'h10, 32'h5555_5555, 0, 1'b0, 32'h0);
        do_req(1'b0, 3'b011, 32'h8000, 32'h0, 0, 1'b0, 32'h0);
        check("err_word_intact", dmem[4], 32'h12AA_BEEF);

        do_req(1'b0, 3'b011, 32'h10, 32'h0, 5, 1'b1, 32'h12AA_BEEF);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 0, 1'b1, 32'hFFFF_FFEF);

        do_req(1'b1, 3'b000, 32'h40, 32'h0000_0011, 0, 1'b0, 32'h0);
        do_req(1'b1, 3'b000, 32'h43, 32'h0000_0022, 0, 1'b0, 32'h0);
        do_req(1'b1, 3'b001, 32'h40, 32'h0000_3344, 0, 1'b0, 32'h0);
        do_req(1'b0, 3'b011, 32'h40, 32'h0, 0, 1'b1, 32'h3344_0022);
        do_req(1'b1, 3'b001, 32'h42, 32'h0000_8001, 0, 1'b0, 32'h0);
        do_req(1'b0, 3'b001, 32'h42, 32'h0, 0, 1'b1, 32'hFFFF_8001);
        do_req(1'b0, 3'b100, 32'h43, 32'h0, 0, 1'b1, 32'h0000_0001);
        do_req(1'b1, 3'b011, 32'h7FFC, 32'hA5A5_0F0F, 2, 1'b0, 32'h0);
        do_req(1'b0, 3'b101, 32'h7FFE, 32'h0, 0, 1'b1, 32'h0000_0F0F);
        do_req(1'b0, 3'b000, 32'h7FFC, 32'h0, 0, 1'b1, 32'hFFFF_FFA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
